// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronised, debounced quarter/dollar sensors with jam detection,
// a coin FIFO and a gapped output pulse sequencer. Define COIN_TOTAL_EN to add coin_total.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          q_sense,
    input  logic                          d_sense,
    input  logic                          hold,
    output logic                          Q_in,
    output logic                          D_in,
    output logic                          coin_reject,
    output logic                          coin_jam,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef COIN_TOTAL_EN
    ,
    output logic [11:0]                   coin_total
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, WAIT_LOW} state_t;

    // Index 0 is the quarter slot, index 1 the dollar slot.
    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;
    logic [1:0] accept;
    logic       jam;
    logic       jam_prev_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            jam_prev_reg <= 1'b0;
        end else begin
            sync1_reg    <= {d_sense, q_sense};
            sync2_reg    <= sync1_reg;
            jam_prev_reg <= jam;
        end
    end

    assign jam      = sync2_reg[0] & sync2_reg[1];
    assign coin_jam = jam;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_sensor
            state_t        state_reg, state_next;
            logic [CW-1:0] cnt_reg, cnt_next;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // A jam overrides everything: the coin is returned, so wait for the slot to clear.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                if (jam) begin
                    state_next = WAIT_LOW;
                    cnt_next   = '0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (sync2_reg[gi]) begin
                                state_next = DEBOUNCE;
                                cnt_next   = '0;
                            end
                        end
                        DEBOUNCE: begin
                            if (!sync2_reg[gi]) begin
                                state_next = IDLE;
                                cnt_next   = '0;
                            end else if (cnt_reg == LAST_CNT) begin
                                state_next = ACCEPT;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt_reg + 1'b1;
                            end
                        end
                        ACCEPT: begin
                            state_next = WAIT_LOW;
                            cnt_next   = '0;
                        end
                        WAIT_LOW: begin
                            if (sync2_reg[gi]) begin
                                cnt_next = '0;
                            end else if (cnt_reg == LAST_CNT) begin
                                state_next = IDLE;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt_reg + 1'b1;
                            end
                        end
                        default: begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            assign accept[gi] = (state_reg == ACCEPT);
        end
    endgenerate

    // Enqueue arbitration; a simultaneous quarter is parked for one cycle behind the dollar.
    logic pending_reg, pending_next;
    logic push, push_code;

    always_comb begin
        push         = 1'b0;
        push_code    = 1'b0;
        pending_next = pending_reg;
        if (jam) begin
            pending_next = 1'b0;
        end else if (accept[1]) begin
            push         = 1'b1;
            push_code    = 1'b1;
            pending_next = accept[0];
        end else if (accept[0]) begin
            push = 1'b1;
        end else if (pending_reg) begin
            push         = 1'b1;
            pending_next = 1'b0;
        end
    end

    // FIFO and output sequencer.
    logic          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic          q_pulse_reg, d_pulse_reg, reject_reg;
    logic          full, pop, wr_en, drop;

    assign full  = (count_reg == FULL_CNT);
    assign pop   = (count_reg != '0) && !hold && !(q_pulse_reg || d_pulse_reg);
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        count_next = count_reg;
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_code;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_reg <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            q_pulse_reg <= 1'b0;
            d_pulse_reg <= 1'b0;
            reject_reg  <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            count_reg   <= count_next;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            q_pulse_reg <= pop && !mem[rd_ptr_reg];
            d_pulse_reg <= pop && mem[rd_ptr_reg];
            reject_reg  <= drop || (jam && !jam_prev_reg);
        end
    end

    assign Q_in        = q_pulse_reg;
    assign D_in        = d_pulse_reg;
    assign coin_reject = reject_reg;
    assign fifo_count  = count_reg;

`ifdef COIN_TOTAL_EN
    logic [11:0] total_reg;
    logic [12:0] total_sum;

    assign total_sum = {1'b0, total_reg}
                     + (q_pulse_reg ? 13'd25 : 13'd0)
                     + (d_pulse_reg ? 13'd100 : 13'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            total_reg <= '0;
        end else begin
            total_reg <= (total_sum > 13'd4095) ? 12'hFFF : total_sum[11:0];
        end
    end

    assign coin_total = total_reg;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus random sensor/hold/reset
// traffic compared every cycle against a run-length/queue model of the acceptor.
module tb_coin_acceptor;
    localparam int DC    = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       q_sense = 1'b0;
    logic       d_sense = 1'b0;
    logic       hold = 1'b0;
    logic       Q_in, D_in, coin_reject, coin_jam;
    logic [2:0] fifo_count;
`ifdef COIN_TOTAL_EN
    logic [11:0] coin_total;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .q_sense     (q_sense),
        .d_sense     (d_sense),
        .hold        (hold),
        .Q_in        (Q_in),
        .D_in        (D_in),
        .coin_reject (coin_reject),
        .coin_jam    (coin_jam),
`ifdef COIN_TOTAL_EN
        .coin_total  (coin_total),
`endif
        .fifo_count  (fifo_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A slot is "armed" once it has seen DC consecutive low samples; an armed slot
    // accepts a coin after DC+1 consecutive high samples. A jam disarms both slots.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_armed [2];
    int m_high [2];
    int m_low [2];
    bit m_acc [2];
    bit m_pend;
    bit m_jam_prev;
    int mq[$];
    bit m_Q, m_D, m_rej;
    int m_total;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_armed[i] = 1;
            m_high[i] = 0; m_low[i] = 0; m_acc[i] = 0;
        end
        m_pend = 0; m_jam_prev = 0; mq.delete();
        m_Q = 0; m_D = 0; m_rej = 0; m_total = 0;
    endtask

    task automatic model_step();
        bit jam, push, pop, full, was_acc;
        bit sv [2];
        int code, popped;
        if (!rstn) begin
            model_reset();
            return;
        end
        if (m_Q) m_total += 25;
        if (m_D) m_total += 100;
        if (m_total > 4095) m_total = 4095;

        sv[0] = m_s2[0]; sv[1] = m_s2[1];
        jam = sv[0] && sv[1];
        push = 0; code = 0;
        if (jam) begin
            m_pend = 0;
        end else if (m_acc[1]) begin
            push = 1; code = 1;
            if (m_acc[0]) m_pend = 1;
        end else if (m_acc[0]) begin
            push = 1;
        end else if (m_pend) begin
            push = 1; m_pend = 0;
        end

        pop  = (mq.size() > 0) && !hold && !(m_Q || m_D);
        full = (mq.size() == DEPTH);
        m_rej = (jam && !m_jam_prev) || (push && full && !pop);
        m_Q = 0; m_D = 0;
        if (pop) begin
            popped = mq.pop_front();
            if (popped == 1) m_D = 1; else m_Q = 1;
        end
        if (push && !(full && !pop)) mq.push_back(code);

        for (int i = 0; i < 2; i++) begin
            was_acc = m_acc[i];
            m_acc[i] = 0;
            if (jam || was_acc) begin
                m_armed[i] = 0; m_low[i] = 0;
            end else if (m_armed[i]) begin
                if (sv[i]) begin
                    m_high[i]++;
                    if (m_high[i] == DC + 1) begin
                        m_acc[i] = 1; m_high[i] = 0;
                    end
                end else begin
                    m_high[i] = 0;
                end
            end else begin
                if (!sv[i]) begin
                    m_low[i]++;
                    if (m_low[i] == DC) begin
                        m_armed[i] = 1; m_high[i] = 0;
                    end
                end else begin
                    m_low[i] = 0;
                end
            end
        end
        m_jam_prev = jam;
        m_s2[0] = m_s1[0]; m_s2[1] = m_s1[1];
        m_s1[0] = q_sense; m_s1[1] = d_sense;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("Q_in", int'(Q_in), int'(m_Q));
            chk("D_in", int'(D_in), int'(m_D));
            chk("coin_reject", int'(coin_reject), int'(m_rej));
            chk("coin_jam", int'(coin_jam), int'(m_s2[0] && m_s2[1]));
            chk("fifo_count", int'(fifo_count), mq.size());
`ifdef COIN_TOTAL_EN
            chk("coin_total", int'(coin_total), m_total);
`endif
        end
    end

    // ---------------- directed stimulus helpers ----------------
    int cyc;
    int nq, nd, nrej, njam;
    int q_times[$];
    int d_times[$];
    int mq_times[$];

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        if (Q_in) begin nq++; q_times.push_back(cyc); end
        if (D_in) begin nd++; d_times.push_back(cyc); end
        if (m_Q) mq_times.push_back(cyc);
        if (coin_reject) nrej++;
        if (coin_jam) njam++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clr();
        cyc = 0; nq = 0; nd = 0; nrej = 0; njam = 0;
        q_times.delete(); d_times.delete(); mq_times.delete();
    endtask

    task automatic coin(input bit dollar, input int hi, input int lo);
        if (dollar) d_sense = 1'b1; else q_sense = 1'b1;
        ticks(hi);
        d_sense = 1'b0; q_sense = 1'b0;
        ticks(lo);
    endtask

    initial begin
        int qrem, drem, hrem;
        qrem = 0; drem = 0; hrem = 0;
        clr();

        // Reset state
        ticks(3);
        chk("reset_Q_in", int'(Q_in), 0);
        chk("reset_D_in", int'(D_in), 0);
        chk("reset_reject", int'(coin_reject), 0);
        chk("reset_jam", int'(coin_jam), 0);
        chk("reset_count", int'(fifo_count), 0);
        rstn = 1'b1;
        ticks(3);

        // Clean 10-cycle quarter: one pulse, synced rise at tick 2, pulse at tick 9
        clr();
        q_sense = 1'b1;
        ticks(10);
        q_sense = 1'b0;
        ticks(20);
        chk("q_clean_count", nq, 1);
        chk("q_clean_latency", (q_times.size() > 0) ? q_times[0] : -1, 9);
        chk("model_q_latency", (mq_times.size() > 0) ? mq_times[0] : -1, 9);
        chk("q_clean_no_D", nd, 0);
        chk("q_clean_fifo_empty", int'(fifo_count), 0);

        // Bouncing dollar then held high
        clr();
        d_sense = 1'b1; tick();
        d_sense = 1'b0; tick();
        d_sense = 1'b1; tick();
        d_sense = 1'b0; tick();
        d_sense = 1'b1; ticks(30);
        d_sense = 1'b0; ticks(20);
        chk("d_bounce_count", nd, 1);
        chk("d_bounce_no_reject", nrej, 0);
        chk("d_bounce_no_Q", nq, 0);

        // hold=1, five quarters: FIFO fills to 4, fifth rejected
        clr();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) coin(1'b0, 8, 8);
        ticks(4);
        chk("hold_fifo_full", int'(fifo_count), 4);
        chk("hold_reject_once", nrej, 1);
        chk("hold_no_pulse", nq + nd, 0);
        clr();
        hold = 1'b0;
        ticks(20);
        chk("drain_count", nq, 4);
        for (int i = 0; i < 3; i++)
            chk("drain_gap", (q_times.size() > i + 1) ? q_times[i + 1] - q_times[i] : -1, 2);
        chk("drain_empty", int'(fifo_count), 0);

        // Jam: both sensors high for 10 cycles
        clr();
        q_sense = 1'b1; d_sense = 1'b1;
        ticks(10);
        q_sense = 1'b0; d_sense = 1'b0;
        ticks(15);
        chk("jam_cycles", njam, 10);
        chk("jam_reject_once", nrej, 1);
        chk("jam_no_pulse", nq + nd, 0);

        // Dollar inserted before quarter: D first, Q two cycles later
        clr();
        hold = 1'b1;
        coin(1'b1, 8, 8);
        coin(1'b0, 8, 8);
        chk("dq_buffered", int'(fifo_count), 2);
        hold = 1'b0;
        ticks(10);
        chk("dq_D_count", nd, 1);
        chk("dq_Q_count", nq, 1);
        chk("dq_order_gap",
            (d_times.size() > 0 && q_times.size() > 0) ? q_times[0] - d_times[0] : -1, 2);

        // Reset with 3 coins buffered and a quarter mid-debounce
        clr();
        hold = 1'b1;
        coin(1'b0, 8, 8);
        coin(1'b1, 8, 8);
        coin(1'b0, 8, 8);
        chk("rst_buffered", int'(fifo_count), 3);
        q_sense = 1'b1;
        ticks(4);
        rstn = 1'b0;
        #1;
        chk("rst_Q_in", int'(Q_in), 0);
        chk("rst_D_in", int'(D_in), 0);
        chk("rst_reject", int'(coin_reject), 0);
        chk("rst_jam", int'(coin_jam), 0);
        chk("rst_count", int'(fifo_count), 0);
`ifdef COIN_TOTAL_EN
        chk("rst_total", int'(coin_total), 0);
`endif
        q_sense = 1'b0;
        ticks(2);
        rstn = 1'b1;
        hold = 1'b0;
        clr();
        ticks(30);
        chk("rst_no_pulse", nq + nd, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if (qrem == 0) begin
                q_sense = ($urandom_range(0, 9) < 5);
                qrem = $urandom_range(1, 14);
            end
            if (drem == 0) begin
                d_sense = ($urandom_range(0, 9) < 4);
                drem = $urandom_range(1, 14);
            end
            if (hrem == 0) begin
                hold = ($urandom_range(0, 9) < 4);
                hrem = $urandom_range(1, 20);
            end
            qrem--; drem--; hrem--;
            rstn = ($urandom_range(0, 799) != 0);
            tick();
        end
        rstn = 1'b1; q_sense = 1'b0; d_sense = 1'b0; hold = 1'b0;
        ticks(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 The block SHALL have the parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable-high samples needed to accept a coin (legal range 2..15).
REQ-002 The block SHALL have the parameter FIFO_DEPTH, default 4, giving the number of accepted coins buffered (power of 2, 2..16).
REQ-003 Port clk  in  1  sole clock; all logic samples on its rising edge.
REQ-004 Port rstn  in  1  reset, asynchronous and active-low.
REQ-005 Port q_sense  in  1  raw quarter-slot sensor, asynchronous and bouncy.
REQ-006 Port d_sense  in  1  raw dollar-slot sensor, asynchronous and bouncy.
REQ-007 Port hold  in  1  downstream busy; while 1, no new coin is issued.
REQ-008 Port Q_in  out  1  one-cycle pulse, one quarter delivered to the vending machine.
REQ-009 Port D_in  out  1  one-cycle pulse, one dollar delivered.
REQ-010 Port coin_reject  out  1  one-cycle pulse, a coin was returned (FIFO full or jam).
REQ-011 Port coin_jam  out  1  level; both sensors are high at once.
REQ-012 Port fifo_count  out  $clog2(FIFO_DEPTH)+1  number of coins currently buffered.

Function
REQ-013 Each sensor input SHALL pass through a 2-flop synchronizer before use; debounce counting SHALL start from the second flop's output.
REQ-014 Each sensor SHALL have its own FSM with states IDLE, DEBOUNCE, ACCEPT and WAIT_LOW.
REQ-015 From IDLE, the FSM SHALL go to DEBOUNCE when the synced sensor is 1, with its counter cleared.
REQ-016 In DEBOUNCE, the counter SHALL increment while the synced sensor is 1.
REQ-017 In DEBOUNCE, the FSM SHALL return to IDLE if the synced sensor is 0 before the count is reached.
REQ-018 In DEBOUNCE, the FSM SHALL go to ACCEPT when the counter reaches DEBOUNCE_CYCLES-1.
REQ-019 ACCEPT SHALL last exactly one cycle, issue one enqueue request, and then go to WAIT_LOW.
REQ-020 WAIT_LOW SHALL return to IDLE only after the synced sensor has been 0 for DEBOUNCE_CYCLES consecutive cycles; a held sensor SHALL count as one coin.
REQ-021 coin_jam SHALL be 1 in any cycle where both synced sensors are 1.
REQ-022 On entry to coin_jam, both FSMs SHALL be forced to WAIT_LOW, no coin SHALL be enqueued, and coin_reject SHALL pulse once.
REQ-023 If both FSMs reach ACCEPT in the same cycle without a jam, the dollar SHALL be enqueued that cycle and the quarter the next cycle, using a 1-entry pending register.
REQ-024 The FIFO SHALL hold 1-bit coin codes (0 = quarter, 1 = dollar).
REQ-025 An enqueue while fifo_count == FIFO_DEPTH SHALL drop the coin and pulse coin_reject.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 Output sequencer: when hold is 0 and the FIFO is non-empty, it SHALL pop one entry and assert Q_in or D_in on the next cycle for exactly one cycle, then force one idle gap cycle.
REQ-028 As a result, pulses SHALL never be back-to-back, and Q_in and D_in SHALL never be 1 together.
REQ-029 hold SHALL be sampled only at pop decision; a pulse already scheduled SHALL complete even if hold rises.
REQ-030 A push and a pop in the same cycle on a full FIFO SHALL be accepted, leaving fifo_count unchanged.
REQ-031 A push and a pop in the same cycle on an empty FIFO SHALL NOT bypass the FIFO; the pop waits one cycle.
REQ-032 Latency from synced sensor high to the output pulse, with an empty FIFO and hold=0, SHALL be DEBOUNCE_CYCLES+3 clocks.

Reset
REQ-033 While rstn=0: FSMs in IDLE, counters 0, synchronizers 0, FIFO empty, pending clear.
REQ-034 While rstn=0: Q_in=0, D_in=0, coin_reject=0, coin_jam=0, fifo_count=0.
REQ-035 A reset asserted mid-debounce or mid-pulse SHALL discard all buffered and in-flight coins, with no pulse after release.
REQ-036 After rstn releases, the first possible output pulse SHALL be no earlier than DEBOUNCE_CYCLES+3 clocks.

Configuration
REQ-037 With COIN_TOTAL_EN defined, the block SHALL add output coin_total [11:0], the delivered value in cents.
REQ-038 coin_total SHALL add 25 per Q_in and 100 per D_in, saturate at 4095, and reset to 0.
REQ-039 Without COIN_TOTAL_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-040 Reset, then a 10-cycle clean q_sense pulse with hold=0 -> exactly one Q_in pulse, 7 clocks after synced rise; fifo_count returns to 0.
REQ-041 d_sense bounces 1,0,1,0 then holds 1 for 30 cycles -> exactly one D_in pulse, no coin_reject.
REQ-042 hold=1, then 5 quarters inserted -> fifo_count reaches 4, coin_reject pulses once; on releasing hold -> 4 Q_in pulses, each separated by one idle cycle.
REQ-043 q_sense and d_sense high together for 10 cycles -> coin_jam=1 throughout, one coin_reject pulse, no Q_in or D_in.
REQ-044 Quarter and dollar accepted in the same cycle via staggered bounce -> D_in pulse first, then Q_in two cycles later.
REQ-045 rstn dropped while 3 coins are buffered -> outputs 0 immediately; no pulses after release; with COIN_TOTAL_EN, coin_total=0.
